serial_reduce: RTL and testbench
================================

Name: serial_reduce

Overview:
- Bit-serial counterpart to the parallel gate and reduction blocks.
- Accepts a serial bit stream over a valid/ready handshake, one bit per beat.
- Deserializes each frame of WIDTH bits into a parallel word and computes the AND, OR and XOR reductions of that frame.
- Presents the result on a valid/ready output port. Sits between a serial link front-end and the parallel logic datapath.

Parameters:
- WIDTH, 8, frame length in bits; legal range 2..32.

Ports:
- clk        input   1       rising-edge clock
- reset      input   1       synchronous, active-high reset
- in_valid   input   1       in_bit is valid this cycle
- in_ready   output  1       block accepts a bit this cycle
- in_bit     input   1       serial data, LSB of frame first
- out_valid  output  1       frame result valid
- out_ready  input   1       consumer takes result this cycle
- out_data   output  WIDTH   reconstructed frame, first bit at [0]
- yand       output  1       AND of all WIDTH frame bits
- yor        output  1       OR of all WIDTH frame bits
- yxor       output  1       XOR (parity) of all WIDTH frame bits

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on port reset.
- Reset, sampled on a clk edge:
  - state=COLLECT, bit counter=0.
  - Accumulators set to identity: and_acc=1, or_acc=0, xor_acc=0, shift word=0.
  - out_valid=0, out_data=0, yand=0, yor=0, yxor=0.
  - in_ready is 0 while reset is high.
- Accept: beat accepted when in_valid && in_ready.
- FSM states: COLLECT, HOLD.
- COLLECT:
  - in_ready=1, out_valid=0.
  - On accept: word[cnt]<=in_bit; and_acc&=in_bit; or_acc|=in_bit; xor_acc^=in_bit; cnt<=cnt+1.
  - When the accepted beat has cnt==WIDTH-1: load out_data/yand/yor/yxor from the final accumulated values (including this bit), cnt<=0, reset accumulators to identity, go to HOLD.
  - No accept (in_valid low): all state holds. Gaps are allowed anywhere in a frame.
- HOLD:
  - out_valid=1, in_ready=0. Outputs stable until handshake.
  - On out_ready=1: go to COLLECT. out_valid drops next cycle; out_data/yand/yor/yxor keep their last values but are don't-care while out_valid=0.
- Latency: out_valid rises on the clk edge that accepts the WIDTH-th bit (visible the cycle after it is presented).
- Throughput: at most one frame per WIDTH+1 cycles. in_ready is low for exactly one cycle between back-to-back frames when out_ready is held high.
- Counter width: $clog2(WIDTH). Never exceeds WIDTH-1; no wrap beyond frame.
- Reset mid-frame: partial frame discarded, counter and accumulators cleared.
- Reset in HOLD: pending result dropped, out_valid=0 the next cycle.
- in_bit is ignored whenever in_ready=0, and whenever in_valid=0 in COLLECT.
- out_ready is ignored in COLLECT.
- No X-propagation: all registers have defined reset values.

Optional Feature:
- Macro: SERIAL_REDUCE_COUNT_EN.
- Defined:
  - Adds output port ones_count, width $clog2(WIDTH+1): the number of 1 bits in the frame.
  - Accumulated serially, reset to 0, and loaded and held like yand.
  - Satisfies yxor==ones_count[0], yand==(ones_count==WIDTH), yor==(ones_count!=0).
- Undefined: port and counter logic are absent; all other behaviour is identical.

Test Plan:
- WIDTH=8, bits 1,1,1,1,1,1,1,1 contiguous, out_ready=1:
  - out_valid high the cycle after the 8th bit is presented, one cycle wide.
  - out_data=8'hFF, yand=1, yor=1, yxor=0.
- Frame 8'hA5 sent LSB first (1,0,1,0,0,1,0,1) with in_valid dropped 2 cycles after bits 3 and 6 -> out_data=8'hA5, yand=0, yor=1, yxor=0.
- Frame 8'h00, out_ready held 0 for 5 cycles after out_valid:
  - out_valid, out_data=0, yand=0, yor=0, yxor=0 stay stable throughout.
  - in_ready=0 throughout; in_bit toggling during the hold is ignored.
- Back-to-back frames 8'h01 then 8'h80, in_valid and out_ready always 1:
  - Both frames give yxor=1, yand=0, yor=1.
  - in_ready low for exactly 1 cycle between frames; total 18 cycles.
- Reset asserted after 3 accepted bits of 1, then frame 8'h0F sent -> out_data=8'h0F, yand=0, yor=1, yxor=0 (no corruption from the partial frame).
- With SERIAL_REDUCE_COUNT_EN defined: 8'hA5 gives ones_count=4; 8'hFF gives 8; 8'h00 gives 0. The ones_count consistency relations above hold for each.

Source files
------------

// File: rtl/serial_reduce.sv
// Bit-serial deserializer: collects WIDTH-bit frames LSB first and reports AND/OR/XOR reductions.
// Result appears the cycle after the last bit; in_ready low while a result is held. Optional ones_count via SERIAL_REDUCE_COUNT_EN.
module serial_reduce #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_bit,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             yand,
    output logic             yor,
    output logic             yxor
`ifdef SERIAL_REDUCE_COUNT_EN
    ,
    output logic [$clog2(WIDTH+1)-1:0] ones_count
`endif
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    state_t           state, state_nx;
    logic [CW-1:0]    cnt, cnt_nx;
    logic [WIDTH-1:0] word, word_nx, word_fin;
    logic             and_acc, and_acc_nx;
    logic             or_acc, or_acc_nx;
    logic             xor_acc, xor_acc_nx;
    logic [WIDTH-1:0] out_data_nx;
    logic             yand_nx, yor_nx, yxor_nx;
    logic             accept;
    logic             last_beat;

    assign in_ready  = (state == COLLECT) && !reset;
    assign out_valid = (state == HOLD);
    assign accept    = in_valid && in_ready;
    assign last_beat = (cnt == LAST);

    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        word_nx     = word;
        and_acc_nx  = and_acc;
        or_acc_nx   = or_acc;
        xor_acc_nx  = xor_acc;
        out_data_nx = out_data;
        yand_nx     = yand;
        yor_nx      = yor;
        yxor_nx     = yxor;
        word_fin    = word;
        word_fin[cnt] = in_bit;

        case (state)
            COLLECT: begin
                if (accept) begin
                    if (last_beat) begin
                        // Publish the frame including this bit, then rearm for the next one.
                        out_data_nx = word_fin;
                        yand_nx     = and_acc & in_bit;
                        yor_nx      = or_acc | in_bit;
                        yxor_nx     = xor_acc ^ in_bit;
                        word_nx     = '0;
                        and_acc_nx  = 1'b1;
                        or_acc_nx   = 1'b0;
                        xor_acc_nx  = 1'b0;
                        cnt_nx      = '0;
                        state_nx    = HOLD;
                    end else begin
                        word_nx    = word_fin;
                        and_acc_nx = and_acc & in_bit;
                        or_acc_nx  = or_acc | in_bit;
                        xor_acc_nx = xor_acc ^ in_bit;
                        cnt_nx     = cnt + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_nx = COLLECT;
                end
            end
            default: state_nx = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= COLLECT;
            cnt      <= '0;
            word     <= '0;
            and_acc  <= 1'b1;
            or_acc   <= 1'b0;
            xor_acc  <= 1'b0;
            out_data <= '0;
            yand     <= 1'b0;
            yor      <= 1'b0;
            yxor     <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            word     <= word_nx;
            and_acc  <= and_acc_nx;
            or_acc   <= or_acc_nx;
            xor_acc  <= xor_acc_nx;
            out_data <= out_data_nx;
            yand     <= yand_nx;
            yor      <= yor_nx;
            yxor     <= yxor_nx;
        end
    end

`ifdef SERIAL_REDUCE_COUNT_EN
    localparam int OW = $clog2(WIDTH + 1);

    logic [OW-1:0] ones_acc, ones_acc_nx, ones_count_nx, ones_inc;

    assign ones_inc = {{(OW-1){1'b0}}, in_bit};

    always_comb begin
        ones_acc_nx   = ones_acc;
        ones_count_nx = ones_count;
        if (state == COLLECT && accept) begin
            if (last_beat) begin
                ones_count_nx = ones_acc + ones_inc;
                ones_acc_nx   = '0;
            end else begin
                ones_acc_nx = ones_acc + ones_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ones_acc   <= '0;
            ones_count <= '0;
        end else begin
            ones_acc   <= ones_acc_nx;
            ones_count <= ones_count_nx;
        end
    end
`else
    // Build without the population counter: reductions only.
`endif

endmodule

// File: tb/tb_serial_reduce.sv
// Randomized + directed bench for serial_reduce; a frame-level model predicts each result from the accepted bits.
module tb_serial_reduce;

    localparam int W  = 8;
    localparam int OW = $clog2(W + 1);

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         in_bit = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_data;
    logic         yand, yor, yxor;
`ifdef SERIAL_REDUCE_COUNT_EN
    logic [OW-1:0] ones_count;
`endif

    serial_reduce #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bit    (in_bit),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .yand      (yand),
        .yor       (yor),
        .yxor      (yxor)
`ifdef SERIAL_REDUCE_COUNT_EN
        ,
        .ones_count(ones_count)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Frame-level model: accepted bits gather into cur; completed frames wait in exp_q.
    logic [W-1:0] exp_q[$];
    logic [W-1:0] cur = '0;
    int           cur_n = 0;
    int           cyc = 0;
    int           ir_low = 0;
    int           pop_cyc = 0;
    int           ir_at_pop = 0;
    logic [W-1:0] last_data = '0;
    int           or_mode = 0;
    int           hold_n = 0;

    always @(negedge clk) begin
        logic [W-1:0] f;
        chk("out_valid", out_valid, exp_q.size() != 0);
        chk("in_ready", in_ready, !reset && exp_q.size() == 0);
        if (exp_q.size() != 0 && out_valid) begin
            f = exp_q[0];
            chk("out_data", out_data, f);
            chk("yand", yand, f == {W{1'b1}});
            chk("yor", yor, f != '0);
            chk("yxor", yxor, $countones(f) % 2);
`ifdef SERIAL_REDUCE_COUNT_EN
            chk("ones_count", ones_count, $countones(f));
            chk("rel_xor", yxor, ones_count[0]);
            chk("rel_and", yand, ones_count == W);
            chk("rel_or", yor, ones_count != 0);
`endif
        end
        if (!in_ready && !reset) ir_low++;
        if (reset) begin
            exp_q.delete();
            cur   = '0;
            cur_n = 0;
        end else begin
            if (out_valid && out_ready && exp_q.size() != 0) begin
                void'(exp_q.pop_front());
                last_data = out_data;
                pop_cyc   = cyc;
                ir_at_pop = ir_low;
            end
            if (in_valid && in_ready) begin
                cur[cur_n] = in_bit;
                cur_n++;
                if (cur_n == W) begin
                    exp_q.push_back(cur);
                    cur   = '0;
                    cur_n = 0;
                end
            end
        end
        cyc++;
    end

    // Consumer: 0 always ready, 1 random, 2 stall five cycles per result.
    initial forever begin
        @(posedge clk);
        #1;
        case (or_mode)
            0: out_ready = 1'b1;
            1: out_ready = 1'($urandom_range(1));
            default: begin
                if (out_valid) hold_n++;
                else hold_n = 0;
                out_ready = (hold_n > 5);
            end
        endcase
    end

    task automatic send_frame(input logic [W-1:0] v, input int nbits, input int gap_pct,
                              input logic [W-1:0] gap2);
        for (int i = 0; i < nbits; i++) begin
            int tries;
            bit acc;
            tries = 0;
            acc   = 1'b0;
            while (!acc) begin
                if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                    in_valid = 1'b0;
                    in_bit   = 1'($urandom);
                end else begin
                    in_valid = 1'b1;
                    in_bit   = v[i];
                end
                @(negedge clk);
                acc = in_valid && in_ready;
                @(posedge clk);
                #1;
                tries++;
                if (!acc && tries > 200) begin
                    chk("accept_timeout", 0, 1);
                    in_valid = 1'b0;
                    return;
                end
            end
            if (gap2[i]) begin
                in_valid = 1'b0;
                in_bit   = ~in_bit;
                repeat (2) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain", exp_q.size(), 0);
    endtask

    task automatic pulse_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int k0, ir0, n;
        logic [W-1:0] v;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_yand", yand, 0);
        chk("rst_yor", yor, 0);
        chk("rst_yxor", yxor, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        send_frame(8'hFF, W, 0, '0);
        drain();
        chk("ff_data", last_data, 8'hFF);

        send_frame(8'hA5, W, 0, 8'b0010_0100);
        drain();
        chk("a5_data", last_data, 8'hA5);

        // Stalled consumer: bits offered during the hold must be refused.
        or_mode = 2;
        send_frame(8'h00, W, 0, '0);
        n = 0;
        while (out_valid && n < 20) begin
            in_valid = 1'b1;
            in_bit   = ~in_bit;
            n++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk("hold_len", n, 6);
        drain();
        chk("zero_data", last_data, 8'h00);
        chk("no_leak", cur_n, 0);

        or_mode = 0;
        k0  = cyc;
        ir0 = ir_low;
        send_frame(8'h01, W, 0, '0);
        send_frame(8'h80, W, 0, '0);
        drain();
        chk("b2b_data", last_data, 8'h80);
        chk("b2b_cycles", pop_cyc - k0 + 1, 18);
        chk("b2b_ready_low", ir_at_pop - ir0, 2);

        send_frame(8'hFF, 3, 0, '0);
        pulse_reset();
        send_frame(8'h0F, W, 0, '0);
        drain();
        chk("after_rst_data", last_data, 8'h0F);

        or_mode = 2;
        send_frame(8'h3C, W, 0, '0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        chk("hold_before_rst", out_valid, 1);
        pulse_reset();
        chk("hold_after_rst", out_valid, 0);

        or_mode = 1;
        for (int f = 0; f < 40; f++) begin
            if ($urandom_range(7) == 0) begin
                send_frame(W'($urandom), $urandom_range(1, W - 1), 20, '0);
                pulse_reset();
            end
            v = W'($urandom);
            send_frame(v, W, 30, '0);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
